// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
// Operation encodings follow RISC-V funct3 for the M extension.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_e;

   // Special-case results; truncated to XLEN where used.
   localparam logic [63:0] DIV0_QUOT = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] OVF_REM   = 64'h0000_0000_0000_0000;

   // rs1 is treated as signed for these operations.
   function automatic logic signed_a(input op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   // rs2 is treated as signed for these operations.
   function automatic logic signed_b(input op_e op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the control unit and muldiv_unit.
// Handshake: start is sampled only while the unit is idle; an accepted start
// raises busy on the next cycle; done pulses for exactly one cycle with result
// valid, and busy is low in that cycle. result holds until the next done.
interface muldiv_if #(parameter int XLEN = 64);
   logic            start;
   logic [2:0]      op;
   logic            word;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (output start, op, word, a, b, input busy, done, result);
   modport slave  (input start, op, word, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration of the datapath. Multiply is an MSB-first
// shift-add into the 2N-bit accumulator; divide is one restoring step on the
// remainder held in the low half of the accumulator.
module muldiv_step #(parameter int XLEN = 64) (
   input  logic              is_div_i,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   opnd_i,
   input  logic              bit_i,
   output logic [2*XLEN-1:0] acc_o,
   output logic              q_bit_o
);

   logic [XLEN:0] trial;
   logic [XLEN:0] diff;

   // Single add-shift or subtract-restore iteration.
   always_comb begin
      trial   = {acc_i[XLEN-1:0], bit_i};
      diff    = trial - {1'b0, opnd_i};
      acc_o   = '0;
      q_bit_o = 1'b0;
      if (is_div_i) begin
         if (!diff[XLEN]) begin
            acc_o   = {{XLEN{1'b0}}, diff[XLEN-1:0]};
            q_bit_o = 1'b1;
         end else begin
            acc_o   = {{XLEN{1'b0}}, trial[XLEN-1:0]};
         end
      end else begin
         acc_o = {acc_i[2*XLEN-2:0], 1'b0} + (bit_i ? {{XLEN{1'b0}}, opnd_i} : {(2*XLEN){1'b0}});
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide with start/busy/done.
// Optional macro MULDIV_WORD_EN (effective only with XLEN=64) enables the *W forms.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic   clk,
   input  logic   reset,
   muldiv_if.slave bus,
   output state_e state_o
);

   localparam int CW = $clog2(XLEN + 1);

   state_e            state_q;
   op_e               op_q;
   logic              word_q, neg_q, aneg_q, spec_q, busy_q, done_q;
   logic [CW-1:0]     cnt_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   opnd_q, sh_q, result_q;

   logic              word_eff;
   op_e               op_in, op_eff;
   logic              sa, sb, a_neg, b_neg, is_div, div0, ovf, special;
   logic [XLEN-1:0]   a_val, b_val, ma, mb, most_neg, spec_res, sh_base, sh_d, opnd_d;
   logic [CW-1:0]     cnt_d;
   logic [2*XLEN-1:0] acc_nx, prod;
   logic              q_bit;
   logic [XLEN-1:0]   quo, rem, raw, result_d;

`ifdef MULDIV_WORD_EN
   if (XLEN == 64) begin : g_word
      assign word_eff = bus.word;
   end else begin : g_noword
      logic unused_word;
      assign unused_word = bus.word;
      assign word_eff    = 1'b0;
   end
`else
   logic unused_word;
   assign unused_word = bus.word;
   assign word_eff    = 1'b0;
`endif

   // Operand preparation at acceptance: signedness, magnitudes, special cases.
   always_comb begin
      op_in    = op_e'(bus.op);
      op_eff   = (word_eff && !op_in[2]) ? OP_MUL : op_in;
      sa       = signed_a(op_eff);
      sb       = signed_b(op_eff);
      if (word_eff) begin
         a_val = sa ? XLEN'($signed(bus.a[31:0])) : XLEN'(bus.a[31:0]);
         b_val = sb ? XLEN'($signed(bus.b[31:0])) : XLEN'(bus.b[31:0]);
         most_neg = ~XLEN'(32'h7FFF_FFFF);
      end else begin
         a_val    = bus.a;
         b_val    = bus.b;
         most_neg = XLEN'(1) << (XLEN - 1);
      end
      a_neg    = sa & a_val[XLEN-1];
      b_neg    = sb & b_val[XLEN-1];
      ma       = a_neg ? (XLEN'(0) - a_val) : a_val;
      mb       = b_neg ? (XLEN'(0) - b_val) : b_val;
      is_div   = op_eff[2];
      div0     = is_div && (b_val == '0);
      ovf      = is_div && sb && (a_val == most_neg) && (b_val == '1);
      special  = div0 || ovf;
      if (div0) spec_res = op_eff[1] ? a_val : DIV0_QUOT[XLEN-1:0];
      else      spec_res = op_eff[1] ? OVF_REM[XLEN-1:0] : a_val;
      sh_base  = is_div ? ma : mb;
      sh_d     = special ? spec_res : (word_eff ? (sh_base << (XLEN - 32)) : sh_base);
      opnd_d   = is_div ? mb : ma;
      cnt_d    = word_eff ? CW'(31) : CW'(XLEN - 1);
   end

   muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div_i (op_q[2]),
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .bit_i    (sh_q[XLEN-1]),
      .acc_o    (acc_nx),
      .q_bit_o  (q_bit)
   );

   // Sign fix-up and result selection used in FIN.
   always_comb begin
      prod     = neg_q ? ((2*XLEN)'(0) - acc_q) : acc_q;
      quo      = neg_q ? (XLEN'(0) - sh_q) : sh_q;
      rem      = aneg_q ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
      if (spec_q)           raw = sh_q;
      else if (op_q[2])     raw = op_q[1] ? rem : quo;
      else if (op_q == OP_MUL) raw = prod[XLEN-1:0];
      else                  raw = prod[2*XLEN-1:XLEN];
      result_d = word_q ? XLEN'($signed(raw[31:0])) : raw;
   end

   // Control FSM with counter, operand registers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= OP_MUL;
         word_q   <= 1'b0;
         neg_q    <= 1'b0;
         aneg_q   <= 1'b0;
         spec_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         sh_q     <= '0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  op_q    <= op_eff;
                  word_q  <= word_eff;
                  neg_q   <= a_neg ^ b_neg;
                  aneg_q  <= a_neg;
                  spec_q  <= special;
                  cnt_q   <= cnt_d;
                  acc_q   <= '0;
                  opnd_q  <= opnd_d;
                  sh_q    <= sh_d;
                  busy_q  <= 1'b1;
                  state_q <= special ? FIN : CALC;
               end
            end
            CALC: begin
               acc_q <= acc_nx;
               sh_q  <= {sh_q[XLEN-2:0], q_bit};
               if (cnt_q == '0) state_q <= FIN;
               else             cnt_q   <= cnt_q - CW'(1);
            end
            FIN: begin
               result_q <= result_d;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit (XLEN=64) with a
// scoreboard queue of expected results, latencies and busy lengths.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int XLEN = 64;

   logic   clk = 1'b0;
   logic   reset;
   state_e dbg_state;

   muldiv_if #(.XLEN(XLEN)) bus ();

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .state_o (dbg_state)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   // Scoreboard
   logic [XLEN-1:0] exp_q[$];
   int              lat_q[$];
   int              acc_q[$];
   string           name_q[$];

   int   busy_cnt = 0;
   int   last_done_cyc = -1;
   logic prev_done = 1'b0;
   logic mon_en = 1'b0;

   task automatic push_exp(input logic [XLEN-1:0] e, input int lat, input string n, input int acc);
      exp_q.push_back(e);
      lat_q.push_back(lat);
      name_q.push_back(n);
      acc_q.push_back(acc);
   endtask

   // Monitor: pops the scoreboard whenever done is presented.
   always @(negedge clk) begin
      if (reset) begin
         busy_cnt  = 0;
         prev_done = 1'b0;
      end else if (mon_en) begin
         if (bus.busy && bus.done) begin
            fails++;
            $display("FAIL busy_done_overlap cyc=%0d got busy=1 done=1 need not both", cyc);
         end
         if (bus.done && prev_done) begin
            fails++;
            $display("FAIL done_twice cyc=%0d got two consecutive done cycles need one", cyc);
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            last_done_cyc = cyc;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_done cyc=%0d got result=%h need no done", cyc, bus.result);
            end else begin
               logic [XLEN-1:0] e;
               int l, a;
               string n;
               e = exp_q.pop_front();
               l = lat_q.pop_front();
               a = acc_q.pop_front();
               n = name_q.pop_front();
               if (bus.result !== e) begin
                  fails++;
                  $display("FAIL %s result got %h need %h", n, bus.result, e);
               end
               tests++;
               if (cyc - a + 1 != l) begin
                  fails++;
                  $display("FAIL %s latency got %0d need %0d", n, cyc - a + 1, l);
               end
               tests++;
               if (busy_cnt != l - 1) begin
                  fails++;
                  $display("FAIL %s busy_cycles got %0d need %0d", n, busy_cnt, l - 1);
               end
            end
            busy_cnt = 0;
         end
         prev_done = bus.done;
      end
   end

   // Driver: present one request at the next edge; scramble inputs after acceptance.
   task automatic issue(input logic [2:0] op, input logic w, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] e, input int lat,
                        input string n, input bit push, input bit hold);
      bus.start = 1'b1;
      bus.op    = op;
      bus.word  = w;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk);
      #1;
      if (push) push_exp(e, lat, n, cyc);
      if (!hold) begin
         bus.start = 1'b0;
         bus.op    = 3'($urandom_range(0, 7));
         bus.word  = 1'($urandom_range(0, 1));
         bus.a     = {$urandom(), $urandom()};
         bus.b     = {$urandom(), $urandom()};
      end
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL timeout got %0d pending need 0 after %0d cycles", exp_q.size(), budget);
         exp_q.delete();
         lat_q.delete();
         acc_q.delete();
         name_q.delete();
      end
   endtask

   task automatic run(input logic [2:0] op, input logic w, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [XLEN-1:0] e, input int lat,
                      input string n);
      issue(op, w, a, b, e, lat, n, 1'b1, 1'b0);
      wait_drain(200);
   endtask

   task automatic check(input string n, input logic [XLEN-1:0] got, input logic [XLEN-1:0] need);
      tests++;
      if (got !== need) begin
         fails++;
         $display("FAIL %s got %h need %h", n, got, need);
      end
   endtask

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog got no finish need finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc2;
      int n;
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.word  = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      reset     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy",   XLEN'(bus.busy), '0);
      check("reset_done",   XLEN'(bus.done), '0);
      check("reset_result", bus.result, '0);
      check("reset_state",  XLEN'(dbg_state), XLEN'(IDLE));
      reset  = 1'b0;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      // Main function
      run(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, "mul_7_m3");
      run(3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, "mulhu_max");
      run(3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, "mulhsu_m1_2");
      run(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          64'h4000_0000_0000_0000, 66, "mulh_minmin");
      run(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, "div_m7_2");
      run(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, "rem_m7_2");
      run(3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66, "divu_100_7");
      run(3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 66, "remu_100_7");

      // Special cases
      run(3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, "divu_by0");
      run(3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 2, "remu_by0");
      run(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2, "div_ovf");
      run(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 2, "rem_ovf");

      // Word form
`ifdef MULDIV_WORD_EN
      run(3'd4, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, "divw");
      run(3'd1, 1'b1, 64'h1234_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFB,
          64'hFFFF_FFFF_FFFF_FFF1, 34, "mulh_as_mulw");
`else
      run(3'd4, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'h0000_0000_FFFF_FFFC, 66, "divw_ignored");
`endif

      // start while busy is ignored
      issue(3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 66, "mul_3_5", 1'b1, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op    = 3'd5;
      bus.a     = 64'd100;
      bus.b     = 64'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_drain(200);
      repeat (80) @(posedge clk);
      #1;
      check("idle_after_ignored", XLEN'(bus.busy), '0);

      // start held through done: back-to-back acceptance
      issue(3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66, "b2b_first", 1'b1, 1'b1);
      bus.op = 3'd0;
      bus.a  = 64'd6;
      bus.b  = 64'd7;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      acc2 = cyc;
      push_exp(64'd42, 66, "b2b_second", acc2);
      check("b2b_accept_gap", XLEN'(acc2 - last_done_cyc), XLEN'(1));
      wait_drain(200);

      // Reset mid-operation aborts without done
      issue(3'd4, 1'b0, 64'd1000, 64'd3, '0, 66, "aborted", 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy",   XLEN'(bus.busy), '0);
      check("abort_done",   XLEN'(bus.done), '0);
      check("abort_result", bus.result, '0);
      check("abort_state",  XLEN'(dbg_state), XLEN'(IDLE));
      repeat (100) @(posedge clk);
      #1;

      // Recovery after abort
      run(3'd0, 1'b0, 64'd9, 64'd9, 64'd81, 66, "mul_after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RISC-V M-extension multiply/divide unit with XLEN parametrisation and a start/busy/done handshake. It sits beside the 64-bit ALU in the multicycle datapath. The control unit stalls in an execute state while `busy` is high and writes `result` to the register file on `done`. It adds the MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operations and, optionally, the RV64 word forms.

## Interface
- `XLEN`, default 64: operand/result width; legal values are 32 and 64.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  reset; synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `word`  in  1  selects the RV64 *W form; honoured only when the macro is enabled.
- `a`  in  XLEN  rs1 operand, captured when `start` is accepted.
- `b`  in  XLEN  rs2 operand, captured when `start` is accepted.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  registered result, held until the next `done`.

## Operation
- States:
  - IDLE: start accepted → CALC, or → FIN on a special case.
  - CALC: N iterations, then → FIN.
  - FIN: → IDLE with `done=1`.
- N = XLEN, or 32 for word ops.
- Operands are latched at acceptance. Later changes to `a`, `b`, `op` and `word` have no effect.
- Multiply: radix-2 shift-add on operand magnitudes into a 2N-bit accumulator; the product is negated in FIN if the signs differ.
  - Signedness: MULH signed×signed; MULHSU signed×unsigned; MULHU and MUL unsigned magnitude (the MUL low half is sign-agnostic).
  - MUL returns the low N bits; MULH* return the high N bits.
- Divide: restoring radix-2 on magnitudes, one quotient bit per CALC cycle.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - Signs apply only to the signed ops DIV and REM.
- Special cases bypass CALC (IDLE → FIN):
  - Divide by zero: quotient = all ones; remainder = `a`.
  - Signed overflow (most-negative / −1): quotient = `a`; remainder = 0.
- Word ops use `a[31:0]` and `b[31:0]`; the 32-bit result is sign-extended to XLEN.
- `word=1` together with op 1–3 is executed as MULW.
- `start` while busy is ignored; there is no queueing.
- `start` in the same cycle as `done` is accepted, because the FSM is already in IDLE that cycle.
- Reset, including mid-operation, forces:
  - state IDLE;
  - `busy=0`, `done=0`, `result=0`;
  - counter and accumulators cleared;
  - no `done` for the aborted operation.

## Timing
- The acceptance edge is E0, where `start=1` and the FSM is in IDLE.
- Normal op:
  - `busy=1` after E0.
  - CALC occupies edges E1..EN.
  - FIN → IDLE at EN+1; `done=1` and `busy=0` in the cycle after EN+1.
  - Latency: N+2 edges from `start` to `done` (66 for XLEN=64, 34 for word ops).
- Special case: `done` after E1, i.e. 2-edge latency.
- `done` is never high for two consecutive cycles.
- `busy` and `done` are never high together.

## Configuration
- `MULDIV_WORD_EN` defined, with XLEN=64: the `word` input selects the *W forms as described above.
- Without the macro, or with XLEN=32:
  - `word` is ignored and treated as 0;
  - N is always XLEN;
  - no word-path logic is synthesised.

## Structure
- Shared package `muldiv_pkg` holds:
  - the `op` enum (funct3 values);
  - the FSM state enum {IDLE, CALC, FIN};
  - localparam constants for the special-case results.
- One sub-module, `muldiv_step`: combinational single-iteration datapath (add-shift or subtract-restore).
  - Inputs: accumulator and operand.
  - Outputs: next accumulator and quotient bit.
  - The top level owns the FSM, counter, sign fix-up and result register.

## Test plan
- XLEN=64, MUL a=7, b=−3 → `result=0xFFFF_FFFF_FFFF_FFEB`; `done` 66 edges after acceptance; `busy` high for 65 cycles.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → `0xFFFF_FFFF_FFFF_FFFE`. MULHSU a=−1, b=2 → `0xFFFF_FFFF_FFFF_FFFF`.
- DIV a=−7, b=2 → −3 (`0xFFFF_FFFF_FFFF_FFFD`). REM a=−7, b=2 → −1.
- Special cases, each with `done` after 2 edges:
  - DIVU a=5, b=0 → `0xFFFF_FFFF_FFFF_FFFF`;
  - REMU a=5, b=0 → 5;
  - DIV a=`0x8000_0000_0000_0000`, b=−1 → `0x8000_0000_0000_0000`;
  - REM of the same operands → 0.
- With `MULDIV_WORD_EN`: DIVW a=`0x0000_0001_FFFF_FFF9`, b=2 → `0xFFFF_FFFF_FFFF_FFFD` after 34 edges. Without the macro, the same stimulus → DIV result `0x0000_0000_FFFF_FFFC` after 66 edges.
- Handshake and reset:
  - Assert `reset` at CALC iteration 10 → next cycle `busy=0`, `result=0`, and no `done` ever appears.
  - Pulse `start` while busy → ignored.
  - Hold `start` through `done` → back-to-back operation accepted, with `done` pulsing once per operation.
